pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Program-counter / redirect stage that sits directly downstream of the branch comparator.
//  Computes the control-flow target of the instruction in execute and registers it,
//  aligned with the comparator's registered br. One cycle later it either redirects the
//  fetch PC and flushes the wrong-path instruction, or advances PC by 4.
//  Tracks the wrong-path shadow cycle and traps on misaligned targets.
// PARAMETERS
//  BITS      32  datapath / PC width
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk       in   1     clock, all state updates on posedge
//  rst       in   1     synchronous active-high reset
//  stall     in   1     1 = freeze PC, pipeline regs and state
//  instr     in   32    instruction in execute (same word the branch comparator sees)
//  pc_ex     in   BITS  PC of instr
//  a         in   BITS  rs1 value (JALR base)
//  br        in   1     branch comparator result; refers to instr of previous cycle
//  pc        out  BITS  fetch PC (registered)
//  link      out  BITS  pc_ex+4, combinational, for JAL/JALR rd write
//  flush     out  1     kill instruction now in execute (wrong path)
//  misalign  out  1     sticky instruction-address-misaligned trap
// BEHAVIOUR
//  Reset: pc=RESET_PC, tgt_q=0, ctl_q=0, state=RUN, misalign=0, flush=0. rst overrides
//   stall and any pending redirect.
//  Decode, ctl=1 for these cases:
//   - opcode 1100011 with funct3 in {000,001,100,101,110,111};
//   - opcode 1101111;
//   - opcode 1100111 with funct3=000.
//  Target, modulo 2^BITS (wraps, no overflow flag):
//   - B-type: pc_ex + sext({i[31],i[7],i[30:25],i[11:8],1'b0})
//   - JAL: pc_ex + sext({i[31],i[19:12],i[20],i[30:21],1'b0})
//   - JALR: (a + sext(i[31:20])) & ~1
//  Cycle N (stall=0): tgt_q<=target, ctl_q<=ctl.
//  Cycle N+1: take = br & ctl_q & (state==RUN). flush=take (combinational, 1-cycle).
//  FSM:
//   - RUN:
//     - take & tgt_q[1:0]==0 -> pc<=tgt_q, state<=SHADOW.
//     - take & tgt_q[1:0]!=0 -> misalign<=1, state<=TRAP, pc holds.
//     - else -> pc<=pc+4.
//   - SHADOW: wrong-path cycle; br ignored, flush=0, ctl_q<=0 (drops the shadow
//     instruction's target), pc<=pc+4, state<=RUN.
//   - TRAP: pc holds, flush=0, misalign=1; only rst exits.
//  stall=1: pc, tgt_q, ctl_q, state hold; flush forced 0; take is re-evaluated when stall
//   drops. br is stable across the stall because instr is held.
//  Back-to-back taken branches: the second lies in the SHADOW cycle and is never taken.
//  pc+4 wraps from 2^BITS-4 to 0.
// TESTING
//  1 rst=1 two cycles, RESET_PC=0x100 -> pc=0x100, flush=0, misalign=0; then pc 0x104,0x108.
//  2 BEQ imm=+16 at pc_ex=0x200, br=1 next cycle -> flush=1 one cycle, pc=0x210, next 0x214.
//  3 BNE, br=0 -> flush=0, pc continues +4; JAL imm=-8 at 0x40 -> pc=0x38.
//  4 JALR a=0x1003, imm=0 -> target 0x1002 (misaligned) -> misalign=1, pc frozen until rst.
//  5 Taken BEQ followed by taken JAL in shadow -> only first redirects, one flush pulse.
//  6 stall=1 during N+1 of taken branch for 3 cycles -> pc holds, flush=0; redirect on release.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter / redirect stage: registers the control-flow target of the
// instruction in execute and redirects fetch one cycle later on a taken branch.
module pc_unit #(
    parameter int              BITS     = 32,
    parameter logic [BITS-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic [31:0]     instr,
    input  logic [BITS-1:0] pc_ex,
    input  logic [BITS-1:0] a,
    input  logic            br,
    output logic [BITS-1:0] pc,
    output logic [BITS-1:0] link,
    output logic            flush,
    output logic            misalign
);

    typedef enum logic [1:0] {
        RUN,
        SHADOW,
        TRAP
    } state_t;

    localparam logic [BITS-1:0] FOUR = BITS'(4);

    state_t          state, state_nx;
    logic [BITS-1:0] tgt_q, target, pc_nx;
    logic [BITS-1:0] imm_b, imm_j, imm_i, jalr_sum;
    logic            ctl_q, ctl, ctl_nx, mis_nx, take;
    logic            is_b, is_jal, is_jalr;
    logic [6:0]      op;
    logic [2:0]      f3;

    assign op = instr[6:0];
    assign f3 = instr[14:12];

    // funct3 010/011 are not defined branch conditions
    assign is_b    = (op == 7'b1100011) && (f3 != 3'b010) && (f3 != 3'b011);
    assign is_jal  = (op == 7'b1101111);
    assign is_jalr = (op == 7'b1100111) && (f3 == 3'b000);
    assign ctl     = is_b || is_jal || is_jalr;

    assign imm_b = {{(BITS-13){instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{(BITS-21){instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};
    assign imm_i = {{(BITS-12){instr[31]}}, instr[31:20]};

    assign jalr_sum = a + imm_i;
    assign link     = pc_ex + FOUR;

    always_comb begin
        target = pc_ex + imm_b;
        unique case (1'b1)
            is_jal:  target = pc_ex + imm_j;
            is_jalr: target = {jalr_sum[BITS-1:1], 1'b0};
            default: ;
        endcase
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        mis_nx   = misalign;
        ctl_nx   = ctl;
        take     = br && ctl_q && (state == RUN) && !stall;
        flush    = take;
        unique case (state)
            RUN: begin
                if (take && (tgt_q[1:0] == 2'b00)) begin
                    pc_nx    = tgt_q;
                    state_nx = SHADOW;
                end else if (take) begin
                    mis_nx   = 1'b1;
                    state_nx = TRAP;
                end else begin
                    pc_nx = pc + FOUR;
                end
            end
            SHADOW: begin
                ctl_nx   = 1'b0;
                pc_nx    = pc + FOUR;
                state_nx = RUN;
            end
            default: begin
                mis_nx = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            tgt_q    <= '0;
            ctl_q    <= 1'b0;
            state    <= RUN;
            misalign <= 1'b0;
        end else if (!stall) begin
            pc       <= pc_nx;
            tgt_q    <= target;
            ctl_q    <= ctl_nx;
            state    <= state_nx;
            misalign <= mis_nx;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, redirects, misalign trap, shadow, stall, wrap.
module tb_pc_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BEQ  = 32'h0000_0863;
    localparam logic [31:0] BNE  = 32'h0000_1863;
    localparam logic [31:0] BF2  = 32'h0000_2863;
    localparam logic [31:0] JALM = 32'hFF9F_F06F;
    localparam logic [31:0] JALR = 32'h0000_0067;

    logic        clk = 1'b0;
    logic        rst, stall, br;
    logic [31:0] instr, pc_ex, a;
    logic [31:0] pc, link;
    logic        flush, misalign;
    int          n_cmp = 0;
    int          n_bad = 0;

    pc_unit #(.BITS(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst), .stall(stall), .instr(instr),
        .pc_ex(pc_ex), .a(a), .br(br), .pc(pc), .link(link),
        .flush(flush), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; br = 1'b0;
        instr = NOP; pc_ex = '0; a = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (pc !== 32'h100) begin n_bad++;
            $display("FAIL rst_pc got %h exp %h", pc, 32'h100); end
        n_cmp++; if (flush !== 1'b0) begin n_bad++;
            $display("FAIL rst_flush got %b exp 0", flush); end
        n_cmp++; if (misalign !== 1'b0) begin n_bad++;
            $display("FAIL rst_mis got %b exp 0", misalign); end
        cyc();
        n_cmp++; if (pc !== 32'h104) begin n_bad++;
            $display("FAIL rst_pc1 got %h exp %h", pc, 32'h104); end
        cyc();
        n_cmp++; if (pc !== 32'h108) begin n_bad++;
            $display("FAIL rst_pc2 got %h exp %h", pc, 32'h108); end
    endtask

    task automatic test_beq_taken();
        do_reset();
        instr = BEQ; pc_ex = 32'h200; br = 1'b0;
        #1;
        n_cmp++; if (link !== 32'h204) begin n_bad++;
            $display("FAIL beq_link got %h exp %h", link, 32'h204); end
        n_cmp++; if (flush !== 1'b0) begin n_bad++;
            $display("FAIL beq_flush0 got %b exp 0", flush); end
        cyc();
        instr = NOP; pc_ex = 32'h204; br = 1'b1;
        #1;
        n_cmp++; if (flush !== 1'b1) begin n_bad++;
            $display("FAIL beq_flush got %b exp 1", flush); end
        cyc();
        n_cmp++; if (pc !== 32'h210) begin n_bad++;
            $display("FAIL beq_pc got %h exp %h", pc, 32'h210); end
        n_cmp++; if (flush !== 1'b0) begin n_bad++;
            $display("FAIL beq_shadow_flush got %b exp 0", flush); end
        br = 1'b0;
        cyc();
        n_cmp++; if (pc !== 32'h214) begin n_bad++;
            $display("FAIL beq_pc1 got %h exp %h", pc, 32'h214); end
    endtask

    task automatic test_not_taken_and_jal();
        do_reset();
        instr = BNE; pc_ex = 32'h300; br = 1'b0;
        cyc();
        instr = BF2; br = 1'b0;
        #1;
        n_cmp++; if (flush !== 1'b0) begin n_bad++;
            $display("FAIL bne_flush got %b exp 0", flush); end
        cyc();
        n_cmp++; if (pc !== 32'h108) begin n_bad++;
            $display("FAIL bne_pc got %h exp %h", pc, 32'h108); end
        instr = NOP; br = 1'b1;
        #1;
        n_cmp++; if (flush !== 1'b0) begin n_bad++;
            $display("FAIL f3_010_flush got %b exp 0", flush); end
        instr = JALM; pc_ex = 32'h40; br = 1'b0;
        #1;
        n_cmp++; if (link !== 32'h44) begin n_bad++;
            $display("FAIL jal_link got %h exp %h", link, 32'h44); end
        cyc();
        instr = NOP; br = 1'b1;
        #1;
        n_cmp++; if (flush !== 1'b1) begin n_bad++;
            $display("FAIL jal_flush got %b exp 1", flush); end
        cyc();
        n_cmp++; if (pc !== 32'h38) begin n_bad++;
            $display("FAIL jal_pc got %h exp %h", pc, 32'h38); end
    endtask

    task automatic test_misalign();
        do_reset();
        instr = JALR; a = 32'h1003; br = 1'b0;
        cyc();
        instr = NOP; br = 1'b1;
        #1;
        n_cmp++; if (flush !== 1'b1) begin n_bad++;
            $display("FAIL jalr_flush got %b exp 1", flush); end
        cyc();
        n_cmp++; if (misalign !== 1'b1) begin n_bad++;
            $display("FAIL mis_set got %b exp 1", misalign); end
        n_cmp++; if (pc !== 32'h104) begin n_bad++;
            $display("FAIL mis_pc got %h exp %h", pc, 32'h104); end
        instr = BEQ; pc_ex = 32'h200;
        repeat (3) cyc();
        n_cmp++; if (pc !== 32'h104) begin n_bad++;
            $display("FAIL mis_hold got %h exp %h", pc, 32'h104); end
        n_cmp++; if (flush !== 1'b0) begin n_bad++;
            $display("FAIL mis_flush got %b exp 0", flush); end
        n_cmp++; if (misalign !== 1'b1) begin n_bad++;
            $display("FAIL mis_sticky got %b exp 1", misalign); end
        do_reset();
        #1;
        n_cmp++; if (misalign !== 1'b0) begin n_bad++;
            $display("FAIL mis_clr got %b exp 0", misalign); end
        n_cmp++; if (pc !== 32'h100) begin n_bad++;
            $display("FAIL mis_rst_pc got %h exp %h", pc, 32'h100); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        do_reset();
        instr = BEQ; pc_ex = 32'h200; br = 1'b0;
        cyc();
        instr = JALM; pc_ex = 32'h204; br = 1'b1;
        #1;
        pulses += int'(flush);
        cyc();
        instr = NOP; pc_ex = 32'h208; br = 1'b1;
        #1;
        pulses += int'(flush);
        n_cmp++; if (pc !== 32'h210) begin n_bad++;
            $display("FAIL b2b_pc got %h exp %h", pc, 32'h210); end
        cyc();
        #1;
        pulses += int'(flush);
        n_cmp++; if (pc !== 32'h214) begin n_bad++;
            $display("FAIL b2b_pc1 got %h exp %h", pc, 32'h214); end
        cyc();
        n_cmp++; if (pc !== 32'h218) begin n_bad++;
            $display("FAIL b2b_pc2 got %h exp %h", pc, 32'h218); end
        n_cmp++; if (pulses !== 1) begin n_bad++;
            $display("FAIL b2b_pulses got %0d exp 1", pulses); end
    endtask

    task automatic test_stall();
        do_reset();
        instr = BEQ; pc_ex = 32'h200; br = 1'b0;
        cyc();
        instr = NOP; br = 1'b1; stall = 1'b1;
        #1;
        n_cmp++; if (flush !== 1'b0) begin n_bad++;
            $display("FAIL stall_flush0 got %b exp 0", flush); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (pc !== 32'h104 || flush !== 1'b0) begin n_bad++;
                $display("FAIL stall_hold%0d got %h/%b exp %h/0",
                         i, pc, flush, 32'h104); end
        end
        stall = 1'b0;
        #1;
        n_cmp++; if (flush !== 1'b1) begin n_bad++;
            $display("FAIL stall_rel_flush got %b exp 1", flush); end
        cyc();
        n_cmp++; if (pc !== 32'h210) begin n_bad++;
            $display("FAIL stall_rel_pc got %h exp %h", pc, 32'h210); end
        stall = 1'b1; rst = 1'b1;
        cyc();
        rst = 1'b0; stall = 1'b0;
        n_cmp++; if (pc !== 32'h100) begin n_bad++;
            $display("FAIL rst_over_stall got %h exp %h", pc, 32'h100); end
    endtask

    task automatic test_wrap();
        do_reset();
        instr = JALR; a = 32'hFFFF_FFFD; br = 1'b0;
        cyc();
        instr = NOP; br = 1'b1;
        cyc();
        n_cmp++; if (pc !== 32'hFFFF_FFFC) begin n_bad++;
            $display("FAIL wrap_tgt got %h exp %h", pc, 32'hFFFF_FFFC); end
        n_cmp++; if (misalign !== 1'b0) begin n_bad++;
            $display("FAIL wrap_mis got %b exp 0", misalign); end
        br = 1'b0;
        cyc();
        n_cmp++; if (pc !== 32'h0) begin n_bad++;
            $display("FAIL wrap_pc got %h exp 0", pc); end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; br = 1'b0;
        instr = NOP; pc_ex = '0; a = '0;
        test_reset();
        test_beq_taken();
        test_not_taken_and_jal();
        test_misalign();
        test_back_to_back();
        test_stall();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
